// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 4-digit common-anode 7-segment bus and recovers per-digit hex, dp, error and blank flags.
// Latency STABLE_CYCLES+3 clocks from a pin change to the output update; receive-only, so it never stalls the bus.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_seg_an,
  input  logic [7:0]  i_seg_cat,
  output logic [15:0] o_hex_out,
  output logic [3:0]  o_dp_out,
  output logic [3:0]  o_digit_err,
  output logic [3:0]  o_blank,
  output logic        o_frame_valid,
  output logic        o_stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [11:0]   r_s1;
  logic [11:0]   r_s2;
  logic [11:0]   r_prev;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_seen;
  logic [TW-1:0] r_to_cnt;

  logic [3:0] w_an;
  logic [7:0] w_cat;
  logic       w_stable;
  logic [3:0] w_oh;
  logic [3:0] w_nib;
  logic       w_hit;
  logic       w_blank;
  logic       w_capture;
  logic [3:0] w_seen_upd;
  logic       w_frame;

  assign w_an     = r_s2[11:8];
  assign w_cat    = r_s2[7:0];
  assign w_stable = (r_s2 == r_prev);
  assign w_blank  = (w_cat[6:0] == 7'h7F);

  // Only a single low anode identifies a digit; anything else is not a valid scan slot.
  always_comb begin
    w_oh = 4'b0000;
    case (w_an)
      4'b1110: w_oh = 4'b0001;
      4'b1101: w_oh = 4'b0010;
      4'b1011: w_oh = 4'b0100;
      4'b0111: w_oh = 4'b1000;
      default: w_oh = 4'b0000;
    endcase
  end

  always_comb begin
    w_nib = 4'h0;
    w_hit = 1'b1;
    case (w_cat[6:0])
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  // Firing at CNT_CAP rather than at saturation gives exactly one capture per stable period.
  assign w_capture  = w_stable && (r_cnt == CNT_CAP) && (w_oh != 4'b0000);
  assign w_seen_upd = r_seen | w_oh;
  assign w_frame    = w_capture && (w_seen_upd == 4'hF);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1          <= 12'hFFF;
      r_s2          <= 12'hFFF;
      r_prev        <= 12'hFFF;
      r_cnt         <= '0;
      r_seen        <= 4'h0;
      r_to_cnt      <= '0;
      o_hex_out     <= 16'h0000;
      o_dp_out      <= 4'h0;
      o_digit_err   <= 4'h0;
      o_blank       <= 4'h0;
      o_frame_valid <= 1'b0;
      o_stale       <= 1'b0;
    end else begin
      r_s1   <= {i_seg_an, i_seg_cat};
      r_s2   <= r_s1;
      r_prev <= r_s2;

      if (!w_stable) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end

      o_frame_valid <= w_frame;

      if (w_capture) begin
        for (int i = 0; i < 4; i++) begin
          if (w_oh[i]) begin
            if (w_hit) begin
              o_hex_out[4*i +: 4] <= w_nib;
              o_digit_err[i]      <= 1'b0;
              o_blank[i]          <= 1'b0;
            end else if (w_blank) begin
              o_digit_err[i]      <= 1'b0;
              o_blank[i]          <= 1'b1;
            end else begin
              o_digit_err[i]      <= 1'b1;
              o_blank[i]          <= 1'b0;
            end
            o_dp_out[i] <= ~w_cat[7];
          end
        end
        r_seen <= w_frame ? 4'h0 : w_seen_upd;
      end

      // Counter parks at its last value so stale holds until the next frame.
      if (w_frame) begin
        r_to_cnt <= '0;
        o_stale  <= 1'b0;
      end else if (r_to_cnt != TO_LAST) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
        o_stale  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random bus traffic, checked every cycle against a run-length model.
module tb_seg_scan_decoder;

  localparam int STAB = 16;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  seg_an = 4'hF;
  logic [7:0]  seg_cat = 8'hFF;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  digit_err;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        stale;

  seg_scan_decoder #(.STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_seg_an      (seg_an),
    .i_seg_cat     (seg_cat),
    .o_hex_out     (hex_out),
    .o_dp_out      (dp_out),
    .o_digit_err   (digit_err),
    .o_blank       (blank),
    .o_frame_valid (frame_valid),
    .o_stale       (stale)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Segment table, index = hex value, entry = active-low cathode pattern g..a.
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int seg_to_hex(input logic [6:0] c);
    for (int k = 0; k < 16; k++) if (seg_tbl[k] == c) return k;
    return -1;
  endfunction

  // Model: a pin sample that completes a run of exactly STAB+1 identical samples
  // is captured two edges later (synchroniser delay).
  logic [11:0] q_smp [$];
  int          q_run [$];
  logic [15:0] m_hex;
  logic [3:0]  m_dp, m_err, m_blank, m_seen;
  logic        m_fv, m_stale;
  int          since;

  task automatic model_edge();
    logic [11:0] smp;
    logic [6:0]  c;
    int          run, d, v;
    smp = rst_n ? {seg_an, seg_cat} : 12'hFFF;
    run = (q_smp.size() > 0 && smp == q_smp[$]) ? q_run[$] + 1 : 1;
    q_smp.push_back(smp);
    q_run.push_back(run);
    if (q_smp.size() > 3) begin
      void'(q_smp.pop_front());
      void'(q_run.pop_front());
    end
    m_fv = 1'b0;
    if (!rst_n) begin
      m_hex = '0; m_dp = '0; m_err = '0; m_blank = '0; m_seen = '0;
      m_stale = 1'b0; since = 0;
    end else begin
      if (q_smp.size() == 3 && q_run[0] == STAB + 1 && $countones(~q_smp[0][11:8]) == 1) begin
        d = 0;
        for (int k = 0; k < 4; k++) if (!q_smp[0][8+k]) d = k;
        c = q_smp[0][6:0];
        v = seg_to_hex(c);
        if (v >= 0) begin
          m_hex[4*d +: 4] = v[3:0];
          m_err[d] = 1'b0;
          m_blank[d] = 1'b0;
        end else if (c == 7'h7F) begin
          m_err[d] = 1'b0;
          m_blank[d] = 1'b1;
        end else begin
          m_err[d] = 1'b1;
          m_blank[d] = 1'b0;
        end
        m_dp[d] = ~q_smp[0][7];
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
          m_fv = 1'b1;
          m_seen = 4'h0;
        end
      end
      if (m_fv) begin
        since = 0;
        m_stale = 1'b0;
      end else begin
        if (since < TMO) since++;
        if (since >= TMO) m_stale = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("hex_out", 32'(hex_out), 32'(m_hex));
    chk("dp_out", 32'(dp_out), 32'(m_dp));
    chk("digit_err", 32'(digit_err), 32'(m_err));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("stale", 32'(stale), 32'(m_stale));
  endtask

  int fv_count;

  task automatic drive(input logic [3:0] an, input logic [7:0] cat, input int n);
    seg_an = an;
    seg_cat = cat;
    repeat (n) begin
      tick();
      if (frame_valid) fv_count++;
    end
  endtask

  task automatic do_reset(input int n);
    seg_an = 4'hF;
    seg_cat = 8'hFF;
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  logic [3:0] r_an;
  logic [7:0] r_cat;
  int         sel;

  initial begin
    do_reset(3);
    chk("reset_hex", 32'(hex_out), 32'h0);
    chk("reset_stale", 32'(stale), 32'h0);

    // Idle bus: stale must rise exactly TMO edges after release, no frames.
    fv_count = 0;
    drive(4'hF, 8'hFF, 1000);
    chk("idle_frames", 32'(fv_count), 32'h0);

    drive(4'hE, 8'hA4, 30);
    chk("single_digit", 32'(hex_out[3:0]), 32'h2);
    drive(4'hF, 8'hFF, 20);

    fv_count = 0;
    drive(4'hE, 8'hF9, 40);
    drive(4'hD, 8'hA4, 40);
    drive(4'hB, 8'h30, 40);
    drive(4'h7, 8'h99, 40);
    drive(4'hF, 8'hFF, 20);
    chk("scan_hex", 32'(hex_out), 32'h4321);
    chk("scan_dp", 32'(dp_out), 32'h4);
    chk("scan_frames", 32'(fv_count), 32'h1);

    drive(4'hD, 8'hFE, 40);
    chk("seg_a_err", 32'(digit_err), 32'h2);
    drive(4'hD, 8'hFF, 40);
    chk("blank_d1", 32'(blank), 32'h2);

    drive(4'hF, 8'hFF, 30);
    drive(4'hD, 8'hC0, 10);
    drive(4'hF, 8'hFF, 30);
    drive(4'hC, 8'hC0, 50);
    drive(4'hF, 8'hFF, 30);

    // Hold boundary: 16 samples is one short of a capture, 17 is enough.
    drive(4'hB, 8'h86, STAB);
    drive(4'hF, 8'hFF, 10);
    drive(4'hB, 8'h86, STAB + 1);
    drive(4'hF, 8'hFF, 10);

    // Stale recovery and reset in the middle of a frame.
    do_reset(2);
    drive(4'hF, 8'hFF, 120);
    drive(4'hE, 8'hC0, 25);
    drive(4'hD, 8'hF9, 25);
    do_reset(2);
    fv_count = 0;
    drive(4'hB, 8'hA4, 25);
    drive(4'h7, 8'hB0, 25);
    drive(4'hE, 8'h99, 25);
    chk("after_reset_no_frame", 32'(fv_count), 32'h0);
    drive(4'hD, 8'h92, 25);
    chk("after_reset_frame", 32'(fv_count), 32'h1);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 7) != 0) r_an = ~(4'b0001 << $urandom_range(0, 3));
      else r_an = 4'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 7) r_cat[6:0] = seg_tbl[$urandom_range(0, 15)];
      else if (sel == 7) r_cat[6:0] = 7'h7F;
      else r_cat[6:0] = 7'($urandom);
      r_cat[7] = 1'($urandom_range(0, 1));
      drive(r_an, r_cat, $urandom_range(3, 40));
      if ($urandom_range(0, 59) == 0) do_reset(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
